vec_wb_arbiter: RTL and testbench
=================================

# vec_wb_arbiter

Write-back arbiter and scoreboard for the vector register RAM's single write port. Two producers, the vector execute unit (requester 0) and the vector load unit (requester 1), compete for the port through valid/ready handshakes; a round-robin arbiter grants one per cycle and drives a registered write command to the RAM. A per-register busy scoreboard lets the issue stage stall reads of registers whose write-back is still outstanding.

## Interface
- VEC_SIZE, 32, lane width in bits (16 lanes per vector)
- VEC_INDEX_WIDTH, 4, vector register index width; NREG = 1<<VEC_INDEX_WIDTH
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req0_valid  in  1  execute unit has a write-back
- o_req0_ready  out  1  requester 0 granted this cycle
- i_req0_addr  in  VEC_INDEX_WIDTH  destination register
- i_req0_data  in  [15:0][VEC_SIZE-1:0]  result vector
- i_req1_valid, o_req1_ready, i_req1_addr, i_req1_data: same as requester 0, for the load unit
- i_claim_valid  in  1  issue stage marks a destination as pending
- i_claim_addr  in  VEC_INDEX_WIDTH  register being claimed
- o_busy  out  NREG  bit r set = write to register r outstanding
- o_write_enable  out  1  to RAM write enable
- o_write_addr  out  VEC_INDEX_WIDTH  to RAM write address
- o_write_data  out  [15:0][VEC_SIZE-1:0]  to RAM write data

## Operation
- Handshake: transfer on reqN_valid && reqN_ready. Ready is combinational from valid and arbiter state. Ready never asserts without valid. A requester holds valid, addr and data stable until accepted.
- Arbitration: 1-bit last-grant pointer `lg`.
  - Only one valid: grant it.
  - Both valid: grant requester !lg.
  - Neither valid: no grant.
  - On any grant, lg <= granted index.
- Exactly one grant per cycle maximum. The loser holds valid and is granted the next cycle if still valid (starvation-free: at most 1 cycle wait under contention).
- Output stage: on grant, the next edge registers o_write_enable=1, o_write_addr and o_write_data from the winner. With no grant, o_write_enable <= 0. Addr and data hold their last values when enable=0.
- Scoreboard, per register r, evaluated each edge:
  - set if i_claim_valid && i_claim_addr==r;
  - else clear if o_write_enable && o_write_addr==r;
  - else hold.
  - Claim beats clear for the same register in the same cycle.
- A write-back to a non-busy register is legal: it is written to the RAM and the scoreboard is unchanged.
- Both requesters targeting the same address: each is serialized in grant order, and both writes reach the RAM. The later grant wins the RAM contents.

## Timing
- Reset (i_rst=1 at an edge):
  - o_write_enable=0, o_write_addr=0, o_write_data=0;
  - o_busy=0; lg=1, so requester 0 has priority first;
  - ready outputs are 0 while i_rst=1.
- Reset mid-operation: the pending output write is dropped (enable forced 0) and all busy bits are cleared. Requesters must re-present their data after reset.
- Latency:
  - grant in cycle N; o_write_enable high in cycle N+1;
  - RAM stores the vector at the end of N+1;
  - the busy bit clears at the same edge, so it reads 0 in cycle N+2.
- A reader polling o_busy==0 therefore sees the new data on the RAM read ports.
- Throughput: one write-back per cycle sustained, alternating under contention.
- Claim-to-busy: a claim in cycle N gives busy=1 in N+1.

## Test plan
- Reset: hold i_rst 2 cycles with both valids high -> readies 0, o_write_enable=0, o_busy=0. First cycle after release with both valid -> o_req0_ready=1, o_req1_ready=0.
- Solo writes: req1 valid addr=5 data=lanes 0xA5A5A5A5 for one cycle -> o_req1_ready=1 that cycle. Next cycle: o_write_enable=1, addr=5, same data. Following cycle: enable=0.
- Contention: both valid for 4 cycles (addr 1 and 2) -> grants alternate 0,1,0,1. Write outputs give addrs 1,2,1,2 one cycle later.
- Scoreboard:
  - claim addr 3 -> o_busy[3]=1 next cycle;
  - req0 write addr 3 -> o_busy[3] stays 1 through the output cycle and is 0 the cycle after.
- Claim/clear collision: o_write_enable to addr 7 in the same cycle as claim addr 7 -> o_busy[7]=1 afterwards.
- Reset mid-flight: assert i_rst in the cycle after a grant with busy[4]=1 -> o_write_enable=0 and o_busy=0 next cycle.

Source files
------------

// File: rtl/vec_wb_arbiter.sv
// Write-back arbiter for the vector register RAM write port: round-robin between the execute
// unit (0) and the load unit (1), a registered write stage and a per-register busy scoreboard.
module vec_wb_arbiter #(
    parameter int unsigned VEC_SIZE        = 32,
    parameter int unsigned VEC_INDEX_WIDTH = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst,

    input  logic                                i_req0_valid,
    output logic                                o_req0_ready,
    input  logic [VEC_INDEX_WIDTH-1:0]          i_req0_addr,
    input  logic [15:0][VEC_SIZE-1:0]           i_req0_data,

    input  logic                                i_req1_valid,
    output logic                                o_req1_ready,
    input  logic [VEC_INDEX_WIDTH-1:0]          i_req1_addr,
    input  logic [15:0][VEC_SIZE-1:0]           i_req1_data,

    input  logic                                i_claim_valid,
    input  logic [VEC_INDEX_WIDTH-1:0]          i_claim_addr,
    output logic [(1<<VEC_INDEX_WIDTH)-1:0]     o_busy,

    output logic                                o_write_enable,
    output logic [VEC_INDEX_WIDTH-1:0]          o_write_addr,
    output logic [15:0][VEC_SIZE-1:0]           o_write_data
);

    localparam int unsigned NREG = 1 << VEC_INDEX_WIDTH;

    logic                           lg_q, lg_d;
    logic                           grant0, grant1;
    logic                           we_q, we_d;
    logic [VEC_INDEX_WIDTH-1:0]     wa_q, wa_d;
    logic [15:0][VEC_SIZE-1:0]      wd_q, wd_d;
    logic [NREG-1:0]                busy_q, busy_d;

    // With both valid the requester that did not win last time goes first; lg resets to 1.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!i_rst) begin
            if (i_req0_valid && i_req1_valid) begin
                grant0 = lg_q;
                grant1 = !lg_q;
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    always_comb begin
        lg_d = lg_q;
        we_d = grant0 || grant1;
        wa_d = wa_q;
        wd_d = wd_q;
        if (grant0) begin
            lg_d = 1'b0;
            wa_d = i_req0_addr;
            wd_d = i_req0_data;
        end else if (grant1) begin
            lg_d = 1'b1;
            wa_d = i_req1_addr;
            wd_d = i_req1_data;
        end
    end

    // A claim in the same cycle as the write-back of that register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            if (i_claim_valid && i_claim_addr == VEC_INDEX_WIDTH'(r)) begin
                busy_d[r] = 1'b1;
            end else if (we_q && wa_q == VEC_INDEX_WIDTH'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lg_q   <= 1'b1;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            lg_q   <= lg_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
        end
    end

    assign o_write_enable = we_q;
    assign o_write_addr   = wa_q;
    assign o_write_data   = wd_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Directed table-driven bench for vec_wb_arbiter plus hand-written reset sequences.
module tb_vec_wb_arbiter;

    localparam int unsigned VS = 32;
    localparam int unsigned IW = 4;

    logic               clk;
    logic               rst;
    logic               v0, v1, r0, r1, cv;
    logic [IW-1:0]      a0, a1, ca, wa;
    logic [15:0][VS-1:0] d0, d1, wd;
    logic [15:0]        busy;
    logic               we;

    int total;
    int bad;

    vec_wb_arbiter #(.VEC_SIZE(VS), .VEC_INDEX_WIDTH(IW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req0_valid   (v0),
        .o_req0_ready   (r0),
        .i_req0_addr    (a0),
        .i_req0_data    (d0),
        .i_req1_valid   (v1),
        .o_req1_ready   (r1),
        .i_req1_addr    (a1),
        .i_req1_data    (d1),
        .i_claim_valid  (cv),
        .i_claim_addr   (ca),
        .o_busy         (busy),
        .o_write_enable (we),
        .o_write_addr   (wa),
        .o_write_data   (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [3:0]  a0;
        logic [31:0] w0;
        logic        v1;
        logic [3:0]  a1;
        logic [31:0] w1;
        logic        cv;
        logic [3:0]  ca;
        logic [1:0]  rdy;   // {ready0, ready1} in this cycle
        logic        we;    // registered outputs seen in this cycle
        logic [3:0]  wa;
        logic [31:0] ww;
        logic [15:0] busy;
    } vec_t;

    function automatic logic [15:0][VS-1:0] lanes(input logic [31:0] w);
        logic [15:0][VS-1:0] v;
        for (int i = 0; i < 16; i++) v[i] = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_data(input string name, input logic [31:0] exp);
        total++;
        if (wd !== lanes(exp)) begin
            bad++;
            $display("FAIL %s: lane0 got 0x%0h expected all lanes 0x%0h at %0t",
                     name, wd[0], exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        v0 = t.v0; a0 = t.a0; d0 = lanes(t.w0);
        v1 = t.v1; a1 = t.a1; d1 = lanes(t.w1);
        cv = t.cv; ca = t.ca;
    endtask

    localparam logic [31:0] W1 = 32'h1111_0001;
    localparam logic [31:0] W2 = 32'h2222_0002;
    localparam logic [31:0] W3 = 32'h3333_0003;
    localparam logic [31:0] W4 = 32'h4444_0004;
    localparam logic [31:0] WA = 32'hA5A5_A5A5;
    localparam logic [31:0] W9 = 32'h9999_0009;
    localparam logic [31:0] WB = 32'hBBBB_000A;

    vec_t tbl[16];

    initial begin
        total = 0;
        bad   = 0;
        //          v0 a0 w0   v1 a1 w1   cv ca rdy    we wa ww  busy
        tbl[0]  = '{1, 1, W1,  1, 2, W2,  0, 0, 2'b10, 0, 0, 0,  16'h0000};
        tbl[1]  = '{1, 1, W1,  1, 2, W2,  0, 0, 2'b01, 1, 1, W1, 16'h0000};
        tbl[2]  = '{1, 1, W1,  1, 2, W2,  0, 0, 2'b10, 1, 2, W2, 16'h0000};
        tbl[3]  = '{1, 1, W1,  1, 2, W2,  0, 0, 2'b01, 1, 1, W1, 16'h0000};
        tbl[4]  = '{0, 0, 0,   0, 0, 0,   1, 3, 2'b00, 1, 2, W2, 16'h0000};
        tbl[5]  = '{0, 0, 0,   1, 5, WA,  0, 0, 2'b01, 0, 2, W2, 16'h0008};
        tbl[6]  = '{1, 3, W3,  0, 0, 0,   0, 0, 2'b10, 1, 5, WA, 16'h0008};
        tbl[7]  = '{0, 0, 0,   0, 0, 0,   0, 0, 2'b00, 1, 3, W3, 16'h0008};
        tbl[8]  = '{0, 0, 0,   0, 0, 0,   1, 7, 2'b00, 0, 3, W3, 16'h0000};
        tbl[9]  = '{1, 7, W4,  0, 0, 0,   0, 0, 2'b10, 0, 3, W3, 16'h0080};
        tbl[10] = '{0, 0, 0,   0, 0, 0,   1, 7, 2'b00, 1, 7, W4, 16'h0080};
        tbl[11] = '{0, 0, 0,   0, 0, 0,   0, 0, 2'b00, 0, 7, W4, 16'h0080};
        tbl[12] = '{1, 9, W9,  1, 10, WB, 0, 0, 2'b01, 0, 7, W4, 16'h0080};
        tbl[13] = '{1, 9, W9,  0, 0, 0,   0, 0, 2'b10, 1, 10, WB, 16'h0080};
        tbl[14] = '{0, 0, 0,   0, 0, 0,   0, 0, 2'b00, 1, 9, W9, 16'h0080};
        tbl[15] = '{0, 0, 0,   0, 0, 0,   0, 0, 2'b00, 0, 9, W9, 16'h0080};

        // Reset held two cycles with both requesters valid.
        rst = 1'b1;
        v0 = 1'b1; a0 = '0; d0 = lanes(W1);
        v1 = 1'b1; a1 = '0; d1 = lanes(W2);
        cv = 1'b0; ca = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_ready", {30'd0, r0, r1}, 32'd0);
            check("rst_we", {31'd0, we}, 32'd0);
            check("rst_busy", {16'd0, busy}, 32'd0);
            check("rst_wa", {28'd0, wa}, 32'd0);
            check_data("rst_wd", 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("v%0d_ready", i), {30'd0, r0, r1}, {30'd0, tbl[i].rdy});
            check($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, tbl[i].we});
            check($sformatf("v%0d_wa", i), {28'd0, wa}, {28'd0, tbl[i].wa});
            check_data($sformatf("v%0d_wd", i), tbl[i].ww);
            check($sformatf("v%0d_busy", i), {16'd0, busy}, {16'd0, tbl[i].busy});
            @(posedge clk); #1;
        end

        // Reset mid-flight: claim 4, grant a write to 4, assert reset while it is in the output stage.
        v0 = 1'b0; v1 = 1'b0; cv = 1'b1; ca = 4'd4;
        @(posedge clk); #1;
        cv = 1'b0; v0 = 1'b1; a0 = 4'd4; d0 = lanes(W3);
        @(negedge clk);
        check("mf_busy4", {31'd0, busy[4]}, 32'd1);
        check("mf_grant", {30'd0, r0, r1}, 32'd2);
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b1; a1 = 4'd6; rst = 1'b1;
        @(negedge clk);
        check("mf_we_inflight", {31'd0, we}, 32'd1);
        check("mf_ready_in_rst", {30'd0, r0, r1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mf_we_dropped", {31'd0, we}, 32'd0);
        check("mf_busy_clear", {16'd0, busy}, 32'd0);
        check("mf_prio_after_rst", {30'd0, r0, r1}, 32'd2);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        check("mf_post_we", {31'd0, we}, 32'd1);
        check("mf_post_wa", {28'd0, wa}, 32'd4);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
